// File: rtl/imem_fetch_pkg.sv
// imem_fetch_pkg: shared state type and buffer depth for the instruction fetch controller
package imem_fetch_pkg;
  typedef enum logic {IDLE, RUN} fetch_state_t;
  localparam int FETCH_DEPTH = 2;
endpackage

// File: rtl/fetch_skid_buf.sv
// fetch_skid_buf: 2-entry FIFO holding fetched {instr, pc} pairs
module fetch_skid_buf
  import imem_fetch_pkg::*;
#(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic         i_flush,
  input  logic [W-1:0] i_data,
  output logic [1:0]   o_cnt,
  output logic         o_valid,
  output logic [W-1:0] o_head
);
  logic [W-1:0] r_mem [FETCH_DEPTH];
  logic         r_rd;
  logic         r_wr;
  logic [1:0]   r_cnt;
  logic         w_pop;
  assign w_pop   = i_pop & o_valid;
  assign o_cnt   = r_cnt;
  assign o_valid = r_cnt != 2'd0;
  assign o_head  = r_mem[r_rd];
  // storage, pointers and occupancy; a flush outranks push and pop
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      for (int k = 0; k < FETCH_DEPTH; k++) r_mem[k] <= '0;
      r_rd  <= 1'b0;
      r_wr  <= 1'b0;
      r_cnt <= 2'd0;
    end else if (i_flush) begin
      r_rd  <= 1'b0;
      r_wr  <= 1'b0;
      r_cnt <= 2'd0;
    end else begin
      if (i_push) r_mem[r_wr] <= i_data;
      r_wr  <= i_push ? ~r_wr : r_wr;
      r_rd  <= w_pop ? ~r_rd : r_rd;
      r_cnt <= r_cnt + {1'b0, i_push} - {1'b0, w_pop};
    end
  // the parent's issue credit must keep pushes away from a full buffer
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(i_push && !i_flush && !w_pop && r_cnt == 2'(FETCH_DEPTH)));
endmodule

// File: rtl/imem_fetch_ctrl.sv
// imem_fetch_ctrl: sequential instruction fetch over a 1-cycle-latency memory with redirect and backpressure
module imem_fetch_ctrl
  import imem_fetch_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fetch_en,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_data,
  output logic                  instr_valid,
  output logic [DATA_WIDTH-1:0] instr,
  output logic [ADDR_WIDTH-1:0] instr_pc,
  input  logic                  instr_ready
);
  localparam int EW = DATA_WIDTH + ADDR_WIDTH;
  fetch_state_t          r_state;
  fetch_state_t          w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_pc;
  logic [ADDR_WIDTH-1:0] r_inflight_pc;
  logic                  r_inflight;
  logic [1:0]            w_cnt;
  logic [2:0]            w_credit;
  logic                  w_pop;
  logic                  w_issue;
  logic [EW-1:0]         w_head;
  assign mem_addr = r_pc;
  assign w_pop    = instr_valid & instr_ready;
  assign w_credit = {1'b0, w_cnt} + {2'b0, r_inflight};
  assign instr    = w_head[EW-1:ADDR_WIDTH];
  assign instr_pc = w_head[ADDR_WIDTH-1:0];
  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= IDLE;
    else r_state <= w_state_nxt;
  // next state and issue: a new read only when buffered plus in-flight entries leave room after this pop
  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    w_state_nxt = (r_state == IDLE) ? ((fetch_en & ~redirect_valid) ? RUN : IDLE)
                                    : (fetch_en ? RUN : IDLE);
    w_issue     = (r_state == RUN) & ~redirect_valid &
                  (w_credit < 3'(FETCH_DEPTH) + {2'b0, w_pop});
  end
  // fetch pointer and in-flight tracking; a redirect drops the outstanding read
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_pc          <= RESET_PC;
      r_inflight    <= 1'b0;
      r_inflight_pc <= '0;
    end else if (redirect_valid) begin
      r_pc       <= redirect_pc;
      r_inflight <= 1'b0;
    end else begin
      r_pc          <= w_issue ? r_pc + ADDR_WIDTH'(1) : r_pc;
      r_inflight    <= w_issue;
      r_inflight_pc <= w_issue ? r_pc : r_inflight_pc;
    end
  fetch_skid_buf #(.W(EW)) u_buf (
    .clk     (clk),
    .rst     (rst),
    .i_push  (r_inflight & ~redirect_valid),
    .i_pop   (w_pop & ~redirect_valid),
    .i_flush (redirect_valid),
    .i_data  ({mem_data, r_inflight_pc}),
    .o_cnt   (w_cnt),
    .o_valid (instr_valid),
    .o_head  (w_head)
  );
endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// tb_imem_fetch_ctrl: scoreboard bench for the fetch controller with a 32-bit and a 4-bit address instance
module tb_imem_fetch_ctrl;
  typedef struct packed {
    logic [31:0] ins;
    logic [31:0] pc;
  } exp_t;
  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_en, redirect_valid, instr_ready;
  logic [31:0] redirect_pc, mem_addr, mem_data, instr, instr_pc;
  logic        instr_valid;
  logic        fetch_en4, redirect4, instr_ready4, instr_valid4;
  logic [3:0]  rpc4, mem_addr4, instr_pc4;
  logic [31:0] mem_data4, instr4;
  exp_t        exp_q[$];
  exp_t        exp4_q[$];
  int          n_chk = 0;
  int          n_fail = 0;
  int          n_got4 = 0;

  imem_fetch_ctrl u_dut (
    .clk(clk), .rst(rst), .fetch_en(fetch_en), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .mem_addr(mem_addr), .mem_data(mem_data),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc), .instr_ready(instr_ready)
  );
  imem_fetch_ctrl #(.ADDR_WIDTH(4)) u_dut4 (
    .clk(clk), .rst(rst), .fetch_en(fetch_en4), .redirect_valid(redirect4),
    .redirect_pc(rpc4), .mem_addr(mem_addr4), .mem_data(mem_data4),
    .instr_valid(instr_valid4), .instr(instr4), .instr_pc(instr_pc4), .instr_ready(instr_ready4)
  );

  always #5 clk = ~clk;

  // instruction memory: mem[k] = 0x1000_0000 + k, one cycle read latency
  always @(posedge clk) begin
    mem_data  <= 32'h1000_0000 + mem_addr;
    mem_data4 <= 32'h1000_0000 + {28'd0, mem_addr4};
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_seq(input logic [31:0] start, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back({32'h1000_0000 + start + 32'(i), start + 32'(i)});
  endtask

  // monitor: every accepted instruction must be the next expected one
  always @(negedge clk) begin : mon
    exp_t e;
    if (!rst && instr_valid && instr_ready) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL sb_extra: got pc %0h expected none", instr_pc);
      end else begin
        e = exp_q.pop_front();
        chk("sb_pc", 64'(instr_pc), 64'(e.pc));
        chk("sb_instr", 64'(instr), 64'(e.ins));
      end
    end
  end

  // monitor for the 4-bit address instance
  always @(negedge clk) begin : mon4
    exp_t e;
    if (!rst && instr_valid4 && instr_ready4) begin
      if (exp4_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL w4_extra: got pc %0h expected none", instr_pc4);
      end else begin
        e = exp4_q.pop_front();
        chk("w4_pc", {60'd0, instr_pc4}, 64'(e.pc));
        chk("w4_instr", 64'(instr4), 64'(e.ins));
        n_got4++;
      end
    end
  end

  initial begin
    rst = 1'b1; fetch_en = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; instr_ready = 1'b1;
    fetch_en4 = 1'b0; redirect4 = 1'b0; rpc4 = '0; instr_ready4 = 1'b1;
    cyc(2);
    chk("rst_valid", 64'(instr_valid), 64'd0);
    chk("rst_addr", 64'(mem_addr), 64'd0);
    chk("rst_instr", 64'(instr), 64'd0);
    chk("rst_pc", 64'(instr_pc), 64'd0);
    // start-up latency and streaming
    rst = 1'b0;
    push_seq(32'd0, 16);
    fetch_en = 1'b1;
    cyc(1); chk("lat_c1", 64'(instr_valid), 64'd0);
    cyc(1); chk("lat_c2", 64'(instr_valid), 64'd0);
    for (int k = 0; k < 5; k++) begin
      cyc(1);
      chk("stream_v", 64'(instr_valid), 64'd1);
      chk("stream_pc", 64'(instr_pc), 64'(k));
    end
    // backpressure with pc 4 at the head
    instr_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      cyc(1);
      chk("bp_hold_v", 64'(instr_valid), 64'd1);
      chk("bp_hold_pc", 64'(instr_pc), 64'd4);
      chk("bp_addr", 64'(mem_addr), 64'd6);
    end
    instr_ready = 1'b1;
    for (int k = 5; k < 8; k++) begin
      cyc(1);
      chk("bp_gapfree_v", 64'(instr_valid), 64'd1);
      chk("bp_gapfree_pc", 64'(instr_pc), 64'(k));
    end
    // fill both entries, then redirect
    instr_ready = 1'b0;
    cyc(1);
    redirect_valid = 1'b1; redirect_pc = 32'h40;
    cyc(1);
    redirect_valid = 1'b0; instr_ready = 1'b1;
    exp_q.delete();
    push_seq(32'h40, 16);
    chk("rd_gap1", 64'(instr_valid), 64'd0);
    cyc(1); chk("rd_gap2", 64'(instr_valid), 64'd0);
    cyc(1); chk("rd_v", 64'(instr_valid), 64'd1);
    chk("rd_pc", 64'(instr_pc), 64'h40);
    chk("rd_instr", 64'(instr), 64'h1000_0040);
    cyc(2); chk("pre_hs_pc", 64'(instr_pc), 64'h42);
    // redirect coinciding with the acceptance of pc 0x42
    redirect_valid = 1'b1; redirect_pc = 32'h40;
    cyc(1);
    redirect_valid = 1'b0;
    exp_q.delete();
    push_seq(32'h40, 16);
    chk("hs_gap1", 64'(instr_valid), 64'd0);
    cyc(1); chk("hs_gap2", 64'(instr_valid), 64'd0);
    cyc(1); chk("hs_next_v", 64'(instr_valid), 64'd1);
    chk("hs_next_pc", 64'(instr_pc), 64'h40);
    // stop fetching, drain, redirect while idle
    fetch_en = 1'b0;
    cyc(6);
    chk("idle_drained", 64'(instr_valid), 64'd0);
    chk("idle_addr", 64'(mem_addr), 64'h43);
    exp_q.delete();
    redirect_valid = 1'b1; redirect_pc = 32'h20;
    cyc(1);
    redirect_valid = 1'b0;
    chk("idle_rd_addr", 64'(mem_addr), 64'h20);
    cyc(3);
    chk("idle_rd_v", 64'(instr_valid), 64'd0);
    chk("idle_rd_hold", 64'(mem_addr), 64'h20);
    push_seq(32'h20, 16);
    fetch_en = 1'b1;
    cyc(1); chk("idle_lat1", 64'(instr_valid), 64'd0);
    cyc(1); chk("idle_lat2", 64'(instr_valid), 64'd0);
    cyc(1); chk("idle_lat3_pc", 64'(instr_pc), 64'h20);
    chk("idle_lat3_v", 64'(instr_valid), 64'd1);
    cyc(1);
    // asynchronous reset in the middle of a cycle
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", 64'(instr_valid), 64'd0);
    chk("arst_addr", 64'(mem_addr), 64'd0);
    cyc(2);
    rst = 1'b0;
    exp_q.delete();
    push_seq(32'd0, 16);
    cyc(1); chk("rs_lat1", 64'(instr_valid), 64'd0);
    cyc(1); chk("rs_lat2", 64'(instr_valid), 64'd0);
    for (int k = 0; k < 4; k++) begin
      cyc(1);
      chk("rs_v", 64'(instr_valid), 64'd1);
      chk("rs_pc", 64'(instr_pc), 64'(k));
    end
    fetch_en = 1'b0;
    // address wrap on the 4-bit instance
    for (int i = 0; i < 12; i++) exp4_q.push_back({32'h1000_0000 + 32'((14 + i) % 16), 32'((14 + i) % 16)});
    redirect4 = 1'b1; rpc4 = 4'd14;
    cyc(1);
    redirect4 = 1'b0; fetch_en4 = 1'b1;
    for (int i = 0; i < 20 && n_got4 < 4; i++) cyc(1);
    chk("wrap_count", 64'(n_got4 >= 4), 64'd1);
    fetch_en4 = 1'b0;
    cyc(6);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
